// File: rtl/rv32_pkg.sv
// Shared RV32I decode types: ALU function encoding, opcode/funct constants and
// the issue bundle handed from the issue stage to execute.
package rv32_pkg;

  typedef enum logic [3:0] {
    ALU_ADD      = 4'd0,
    ALU_SUB      = 4'd1,
    ALU_SLL      = 4'd2,
    ALU_SLT      = 4'd3,
    ALU_SLTU     = 4'd4,
    ALU_XOR      = 4'd5,
    ALU_SRL      = 4'd6,
    ALU_SRA      = 4'd7,
    ALU_OR       = 4'd8,
    ALU_AND      = 4'd9,
    ALU_ADD_JALR = 4'd10
  } alu_func_e;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_func_e   func;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wb_en;
    logic        is_branch;
    logic [2:0]  br_funct3;
    logic        is_jump;
    logic [31:0] tgt;
    logic [31:0] link_val;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_wdata;
    logic        illegal;
  } issue_bundle_t;

  // alt selects SUB/SRA where funct7[5] distinguishes the pair
  function automatic alu_func_e f3_func(input logic [2:0] f3, input logic alt);
    alu_func_e f;
    case (f3)
      F3_ADD:  f = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  f = ALU_SLL;
      F3_SLT:  f = ALU_SLT;
      F3_SLTU: f = ALU_SLTU;
      F3_XOR:  f = ALU_XOR;
      F3_SR:   f = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   f = ALU_OR;
      F3_AND:  f = ALU_AND;
      default: f = ALU_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Fetch/regfile/execute-facing signals of the issue stage; slave is the stage,
// master is its environment.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_func;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  rd;
  logic        wb_en;
  logic        is_branch;
  logic [2:0]  br_funct3;
  logic        is_jump;
  logic [31:0] tgt;
  logic [31:0] link_val;
  logic        mem_re;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_wdata;
  logic        illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, alu_func, alu_a, alu_b, rd,
           wb_en, is_branch, br_funct3, is_jump, tgt, link_val, mem_re, mem_we,
           mem_funct3, mem_wdata, illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, alu_func, alu_a, alu_b, rd,
           wb_en, is_branch, br_funct3, is_jump, tgt, link_val, mem_re, mem_we,
           mem_funct3, mem_wdata, illegal
  );
endinterface

// File: rtl/rv32_decode.sv
// Combinational RV32I decoder: instruction, pc and register data to an issue
// bundle. Unsupported encodings collapse to an inert ADD 0,0 marked illegal.
import rv32_pkg::*;

module rv32_decode (
  input  logic [31:0]   instr,
  input  logic [31:0]   pc,
  input  logic [31:0]   rs1_data,
  input  logic [31:0]   rs2_data,
  output issue_bundle_t bundle
);

  logic [6:0]  opc_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [4:0]  rd_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic        writes_s;
  logic        ill_s;

  assign opc_s   = instr[6:0];
  assign rd_s    = instr[11:7];
  assign f3_s    = instr[14:12];
  assign f7_s    = instr[31:25];
  assign imm_i_s = {{20{instr[31]}}, instr[31:20]};
  assign imm_s_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u_s = {instr[31:12], 12'd0};
  assign imm_j_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Opcode-driven operand/function selection, then the illegal override
  always_comb begin
    bundle          = '0;
    bundle.func     = ALU_ADD;
    bundle.link_val = pc + 32'd4;
    writes_s        = 1'b0;
    ill_s           = 1'b0;
    case (opc_s)
      OPC_OP: begin
        bundle.a    = rs1_data;
        bundle.b    = rs2_data;
        bundle.func = f3_func(f3_s, f7_s[5]);
        writes_s    = 1'b1;
        ill_s       = !((f7_s == F7_ZERO) ||
                        ((f7_s == F7_ALT) && ((f3_s == F3_ADD) || (f3_s == F3_SR))));
      end
      OPC_OP_IMM: begin
        bundle.a = rs1_data;
        writes_s = 1'b1;
        if ((f3_s == F3_SLL) || (f3_s == F3_SR)) begin
          bundle.b    = {27'd0, instr[24:20]};
          bundle.func = f3_func(f3_s, f7_s[5]);
          ill_s       = !((f7_s == F7_ZERO) || ((f3_s == F3_SR) && (f7_s == F7_ALT)));
        end else begin
          bundle.b    = imm_i_s;
          bundle.func = f3_func(f3_s, 1'b0);
        end
      end
      OPC_LUI: begin
        bundle.b = imm_u_s;
        writes_s = 1'b1;
      end
      OPC_AUIPC: begin
        bundle.a = pc;
        bundle.b = imm_u_s;
        writes_s = 1'b1;
      end
      OPC_JAL: begin
        bundle.a       = pc;
        bundle.b       = imm_j_s;
        bundle.is_jump = 1'b1;
        bundle.tgt     = pc + imm_j_s;
        writes_s       = 1'b1;
      end
      OPC_JALR: begin
        bundle.a       = rs1_data;
        bundle.b       = imm_i_s;
        bundle.func    = ALU_ADD_JALR;
        bundle.is_jump = 1'b1;
        writes_s       = 1'b1;
        ill_s          = (f3_s != 3'd0);
      end
      OPC_BRANCH: begin
        bundle.a         = rs1_data;
        bundle.b         = rs2_data;
        bundle.func      = ALU_SUB;
        bundle.is_branch = 1'b1;
        bundle.br_funct3 = f3_s;
        bundle.tgt       = pc + imm_b_s;
        ill_s            = (f3_s[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        bundle.a          = rs1_data;
        bundle.b          = imm_i_s;
        bundle.mem_re     = 1'b1;
        bundle.mem_funct3 = f3_s;
        writes_s          = 1'b1;
        case (f3_s)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ill_s = 1'b0;
          default:                             ill_s = 1'b1;
        endcase
      end
      OPC_STORE: begin
        bundle.a          = rs1_data;
        bundle.b          = imm_s_s;
        bundle.mem_we     = 1'b1;
        bundle.mem_funct3 = f3_s;
        bundle.mem_wdata  = rs2_data;
        ill_s             = (f3_s > 3'd2);
      end
      OPC_MISC_MEM: begin
        writes_s = 1'b0;
      end
      default: begin
        ill_s = 1'b1;
      end
    endcase

    if (ill_s) begin
      bundle          = '0;
      bundle.func     = ALU_ADD;
      bundle.link_val = pc + 32'd4;
      bundle.illegal  = 1'b1;
    end else begin
      bundle.rd    = writes_s ? rd_s : 5'd0;
      bundle.wb_en = writes_s && (rd_s != 5'd0);
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage: rv32_decode followed by a valid/ready pipeline register
// with backpressure and flush, feeding the ALU and branch/memory/writeback.
import rv32_pkg::*;

module alu_issue #(
  parameter int unsigned XLEN           = 32,
  parameter logic [31:0] RESET_PC_PLUS4 = 32'd0
) (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
);

  localparam logic [XLEN-1:0] LINK_RST = XLEN'(RESET_PC_PLUS4);

  issue_bundle_t dec_s;
  issue_bundle_t bundle_rst_s;
  issue_bundle_t bundle_d, bundle_q;
  logic          valid_d, valid_q;
  logic          in_ready_s;

  rv32_decode u_decode (
    .instr   (bus.in_instr),
    .pc      (bus.in_pc),
    .rs1_data(bus.rs1_data),
    .rs2_data(bus.rs2_data),
    .bundle  (dec_s)
  );

  assign bus.rs1_addr = bus.in_instr[19:15];
  assign bus.rs2_addr = bus.in_instr[24:20];

  // Reset image: everything zero except the debug link value
  always_comb begin
    bundle_rst_s          = '0;
    bundle_rst_s.link_val = LINK_RST;
  end

  // Next-state: flush wins, otherwise load (or empty) whenever the slot frees up
  always_comb begin
    in_ready_s = !valid_q || bus.out_ready;
    valid_d    = valid_q;
    bundle_d   = bundle_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (in_ready_s) begin
      valid_d = bus.in_valid;
      if (bus.in_valid) begin
        bundle_d = dec_s;
      end else begin
        bundle_d = bundle_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= bundle_rst_s;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = valid_q;
  assign bus.alu_func   = bundle_q.func;
  assign bus.alu_a      = bundle_q.a;
  assign bus.alu_b      = bundle_q.b;
  assign bus.rd         = bundle_q.rd;
  assign bus.wb_en      = bundle_q.wb_en;
  assign bus.is_branch  = bundle_q.is_branch;
  assign bus.br_funct3  = bundle_q.br_funct3;
  assign bus.is_jump    = bundle_q.is_jump;
  assign bus.tgt        = bundle_q.tgt;
  assign bus.link_val   = bundle_q.link_val;
  assign bus.mem_re     = bundle_q.mem_re;
  assign bus.mem_we     = bundle_q.mem_we;
  assign bus.mem_funct3 = bundle_q.mem_funct3;
  assign bus.mem_wdata  = bundle_q.mem_wdata;
  assign bus.illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: table of instructions streamed through a scoreboard,
// plus backpressure, flush and mid-stall reset sequences.
module tb_alu_issue;

  localparam logic [31:0] RST_LINK = 32'hA5A5_0004;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [3:0]  func;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        wb, br;
    logic [2:0]  bf3;
    logic        jmp;
    logic [31:0] tgt, link;
    logic        re, we;
    logic [2:0]  mf3;
    logic [31:0] wdata;
    logic        ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];
  vec_t sb[$];

  alu_issue_if bif ();

  alu_issue #(.XLEN(32), .RESET_PC_PLUS4(RST_LINK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, pc, rs1, rs2);
    vec_t v;
    v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
    v.func = 4'd0; v.a = 32'd0; v.b = 32'd0; v.rd = 5'd0; v.wb = 1'b0;
    v.br = 1'b0; v.bf3 = 3'd0; v.jmp = 1'b0; v.tgt = 32'd0; v.link = pc + 32'd4;
    v.re = 1'b0; v.we = 1'b0; v.mf3 = 3'd0; v.wdata = 32'd0; v.ill = 1'b0;
    return v;
  endfunction

  task automatic check_bundle(input vec_t e);
    cmp("func", {28'd0, bif.alu_func}, {28'd0, e.func});
    cmp("alu_a", bif.alu_a, e.a);
    cmp("alu_b", bif.alu_b, e.b);
    cmp("wb_en", {31'd0, bif.wb_en}, {31'd0, e.wb});
    cmp("is_branch", {31'd0, bif.is_branch}, {31'd0, e.br});
    cmp("is_jump", {31'd0, bif.is_jump}, {31'd0, e.jmp});
    cmp("mem_re", {31'd0, bif.mem_re}, {31'd0, e.re});
    cmp("mem_we", {31'd0, bif.mem_we}, {31'd0, e.we});
    cmp("illegal", {31'd0, bif.illegal}, {31'd0, e.ill});
    cmp("link_val", bif.link_val, e.link);
    if (e.wb) cmp("rd", {27'd0, bif.rd}, {27'd0, e.rd});
    if (e.br || (e.jmp && e.func == 4'd0)) cmp("tgt", bif.tgt, e.tgt);
    if (e.br) cmp("br_funct3", {29'd0, bif.br_funct3}, {29'd0, e.bf3});
    if (e.re || e.we) cmp("mem_funct3", {29'd0, bif.mem_funct3}, {29'd0, e.mf3});
    if (e.we) cmp("mem_wdata", bif.mem_wdata, e.wdata);
  endtask

  // Offer one instruction until accepted (bounded); optionally expect it on the output
  task automatic send(input vec_t v, input bit push);
    int n = 0;
    bif.in_valid = 1'b1; bif.in_instr = v.instr; bif.in_pc = v.pc;
    bif.rs1_data = v.rs1; bif.rs2_data = v.rs2;
    #1;
    while (!bif.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bif.in_ready) begin
      cmp("accept_timeout", 32'd0, 32'd1);
    end else if (push) begin
      sb.push_back(v);
    end
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
  endtask

  // Scoreboard monitor: every bundle taken by execute must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bif.out_valid && bif.out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_issue: got alu_a=%h with no bundle expected", bif.alu_a);
        end else begin
          check_bundle(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vec_t x;
    vec_t y;
    bif.in_valid = 1'b0; bif.in_instr = 32'd0; bif.in_pc = 32'd0;
    bif.rs1_data = 32'd0; bif.rs2_data = 32'd0; bif.flush = 1'b0; bif.out_ready = 1'b1;

    v = mk(32'hFFB10093, 32'h0, 32'd10, 32'd0);
    v.a = 32'd10; v.b = 32'hFFFFFFFB; v.rd = 5'd1; v.wb = 1'b1; vecs.push_back(v);
    v = mk(32'h402081B3, 32'h4, 32'h50, 32'h20);
    v.func = 4'd1; v.a = 32'h50; v.b = 32'h20; v.rd = 5'd3; v.wb = 1'b1; vecs.push_back(v);
    v = mk(32'h40335293, 32'h8, 32'h80000000, 32'h1234);
    v.func = 4'd7; v.a = 32'h80000000; v.b = 32'd3; v.rd = 5'd5; v.wb = 1'b1; vecs.push_back(v);
    v = mk(32'h00208863, 32'h100, 32'd7, 32'd7);
    v.func = 4'd1; v.a = 32'd7; v.b = 32'd7; v.br = 1'b1; v.bf3 = 3'd0; v.tgt = 32'h110; vecs.push_back(v);
    v = mk(32'h000100E7, 32'h200, 32'h3000, 32'd0);
    v.func = 4'd10; v.a = 32'h3000; v.jmp = 1'b1; v.rd = 5'd1; v.wb = 1'b1; vecs.push_back(v);
    v = mk(32'h123453B7, 32'h300, 32'hFFFF, 32'd0);
    v.b = 32'h12345000; v.rd = 5'd7; v.wb = 1'b1; vecs.push_back(v);
    v = mk(32'hFFFFF417, 32'h10, 32'd0, 32'd0);
    v.a = 32'h10; v.b = 32'hFFFFF000; v.rd = 5'd8; v.wb = 1'b1; vecs.push_back(v);
    v = mk(32'hFFDFF0EF, 32'h20, 32'd0, 32'd0);
    v.a = 32'h20; v.b = 32'hFFFFFFFC; v.jmp = 1'b1; v.tgt = 32'h1C; v.rd = 5'd1; v.wb = 1'b1; vecs.push_back(v);
    v = mk(32'h00812483, 32'h30, 32'h400, 32'd0);
    v.a = 32'h400; v.b = 32'd8; v.re = 1'b1; v.mf3 = 3'd2; v.rd = 5'd9; v.wb = 1'b1; vecs.push_back(v);
    v = mk(32'hFE512E23, 32'h40, 32'h400, 32'hDEADBEEF);
    v.a = 32'h400; v.b = 32'hFFFFFFFC; v.we = 1'b1; v.mf3 = 3'd2; v.wdata = 32'hDEADBEEF; vecs.push_back(v);
    v = mk(32'h00208033, 32'h50, 32'd1, 32'd2);
    v.a = 32'd1; v.b = 32'd2; vecs.push_back(v);
    v = mk(32'h0FF0000F, 32'h60, 32'h55, 32'h66);
    vecs.push_back(v);
    v = mk(32'h00000073, 32'h70, 32'h11, 32'h22); v.ill = 1'b1; vecs.push_back(v);
    v = mk(32'h00000000, 32'h80, 32'h9, 32'h9);   v.ill = 1'b1; vecs.push_back(v);
    v = mk(32'h0020A063, 32'h90, 32'd1, 32'd2);   v.ill = 1'b1; vecs.push_back(v);
    v = mk(32'h40209033, 32'hA0, 32'd1, 32'd2);   v.ill = 1'b1; vecs.push_back(v);
    v = mk(32'h7FF0C213, 32'hB0, 32'hF0F0, 32'd0);
    v.func = 4'd5; v.a = 32'hF0F0; v.b = 32'h7FF; v.rd = 5'd4; v.wb = 1'b1; vecs.push_back(v);
    v = mk(32'h02209063, 32'hFFFFFFF0, 32'd1, 32'd2);
    v.func = 4'd1; v.a = 32'd1; v.b = 32'd2; v.br = 1'b1; v.bf3 = 3'd1; v.tgt = 32'h10; vecs.push_back(v);

    // Reset state
    #12;
    cmp("rst_out_valid", {31'd0, bif.out_valid}, 32'd0);
    cmp("rst_link_val", bif.link_val, RST_LINK);
    cmp("rst_alu_a", bif.alu_a, 32'd0);
    cmp("rst_wb_en", {31'd0, bif.wb_en}, 32'd0);
    @(negedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;
    cmp("rst_in_ready", {31'd0, bif.in_ready}, 32'd1);

    // Streamed table, back to back
    foreach (vecs[i]) send(vecs[i], 1'b1);
    repeat (3) @(posedge clk);
    #1;
    cmp("table_drained", sb.size(), 32'd0);

    // Backpressure: X held unchanged while Y waits
    x = vecs[0]; y = vecs[1];
    bif.out_ready = 1'b0;
    send(x, 1'b1);
    bif.in_valid = 1'b1; bif.in_instr = y.instr; bif.in_pc = y.pc;
    bif.rs1_data = y.rs1; bif.rs2_data = y.rs2;
    for (int k = 0; k < 3; k++) begin
      #1;
      cmp("bp_in_ready", {31'd0, bif.in_ready}, 32'd0);
      cmp("bp_out_valid", {31'd0, bif.out_valid}, 32'd1);
      cmp("bp_hold_a", bif.alu_a, x.a);
      cmp("bp_hold_b", bif.alu_b, x.b);
      cmp("bp_hold_rd", {27'd0, bif.rd}, {27'd0, x.rd});
      @(posedge clk); #1;
    end
    bif.out_ready = 1'b1;
    #1;
    cmp("bp_release_ready", {31'd0, bif.in_ready}, 32'd1);
    sb.push_back(y);
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    cmp("bp_second_valid", {31'd0, bif.out_valid}, 32'd1);
    cmp("bp_second_a", bif.alu_a, y.a);
    repeat (2) @(posedge clk);
    #1;
    cmp("bp_drained", sb.size(), 32'd0);

    // Flush kills the held bundle and the instruction offered alongside it
    bif.out_ready = 1'b0;
    send(vecs[2], 1'b0);
    cmp("fl_held_valid", {31'd0, bif.out_valid}, 32'd1);
    bif.flush = 1'b1; bif.in_valid = 1'b1; bif.in_instr = vecs[3].instr;
    bif.in_pc = vecs[3].pc; bif.rs1_data = vecs[3].rs1; bif.rs2_data = vecs[3].rs2;
    @(posedge clk); #1;
    bif.flush = 1'b0; bif.in_valid = 1'b0; bif.out_ready = 1'b1;
    cmp("fl_out_valid", {31'd0, bif.out_valid}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      cmp("fl_stays_empty", {31'd0, bif.out_valid}, 32'd0);
    end
    cmp("fl_no_issue", sb.size(), 32'd0);

    // Asynchronous reset in the middle of a stall
    bif.out_ready = 1'b0;
    send(vecs[4], 1'b0);
    cmp("mr_stalled", {31'd0, bif.out_valid}, 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    cmp("mr_out_valid", {31'd0, bif.out_valid}, 32'd0);
    cmp("mr_link_val", bif.link_val, RST_LINK);
    cmp("mr_alu_a", bif.alu_a, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    bif.out_ready = 1'b1;
    #1;
    cmp("mr_in_ready", {31'd0, bif.in_ready}, 32'd1);
    send(vecs[5], 1'b1);
    cmp("mr_first_valid", {31'd0, bif.out_valid}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    cmp("mr_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage that generates the ALU's `func`, A and B operands from a fetched RV32I instruction.
- Sits between fetch and execute.
- Reads register-file data, builds immediates and maps opcode/funct3/funct7 onto the team's 4-bit ALU function encoding.
- Holds the result in a valid/ready pipeline register, with backpressure and flush, that feeds the ALU and the branch/memory/writeback logic.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC_PLUS4, 0, value driven on link_val during reset (debug visibility only).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- rs1_addr  out  5  regfile read address 1, combinational = in_instr[19:15]
- rs2_addr  out  5  regfile read address 2, combinational = in_instr[24:20]
- rs1_data  in  32  regfile read data 1, same cycle
- rs2_data  in  32  regfile read data 2, same cycle
- flush  in  1  kill the held and incoming instruction
- out_valid  out  1  issued bundle valid
- out_ready  in  1  execute accepts bundle
- alu_func  out  4  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, ADD_JALR=10
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- rd  out  5  destination register
- wb_en  out  1  writeback enable (0 when rd==0)
- is_branch  out  1  conditional branch
- br_funct3  out  3  branch condition, consumed with ALU eq / a_lt_b / a_lt_ub
- is_jump  out  1  JAL/JALR
- tgt  out  32  in_pc+imm for branch/JAL
- link_val  out  32  in_pc+4
- mem_re  out  1  load
- mem_we  out  1  store
- mem_funct3  out  3  access size/sign
- mem_wdata  out  32  rs2_data for stores
- illegal  out  1  unsupported encoding

Behaviour:
- Reset (async, rst_n=0): out_valid=0. All registered outputs are 0, except link_val=RESET_PC_PLUS4. in_ready=1 once rst_n=1.
- Reset mid-operation drops the held bundle with no partial output.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Load on in_valid && in_ready. Latency 1 cycle; throughput 1/cycle when out_ready=1.
  - Bundle is stable while out_valid && !out_ready.
- Flush has priority: out_valid<=0 next cycle; the incoming instruction in the same cycle is discarded.
- Load without a new instruction (in_ready && !in_valid): out_valid<=0.
- Immediates: I, S, B, U, J types, sign-extended to 32 bits.
- Opcode to operand/func mapping:
  - OP (0110011): A=rs1, B=rs2.
    - funct3 maps 000→ADD/SUB (funct7[5]), 001→SLL, 010→SLT, 011→SLTU, 100→XOR, 101→SRL/SRA (funct7[5]), 110→OR, 111→AND.
    - funct7 must be 0000000, or 0100000 for funct3 000/101 only.
  - OP-IMM (0010011): A=rs1, B=immI, same funct3 map with no SUB.
    - Shifts use B={27'b0,shamt}; SLLI/SRLI need funct7=0, SRAI needs 0100000.
  - LUI: A=0, B=immU, ADD.
  - AUIPC: A=pc, B=immU, ADD.
  - JAL: A=pc, B=immJ, ADD, is_jump=1, tgt=pc+immJ, wb=link_val.
  - JALR (funct3 must be 000): A=rs1, B=immI, ADD_JALR, is_jump=1.
  - BRANCH: A=rs1, B=rs2, SUB, is_branch=1, br_funct3=funct3; funct3 010/011 are illegal.
  - LOAD: A=rs1, B=immI, ADD, mem_re=1; funct3 in {000,001,010,100,101}.
  - STORE: A=rs1, B=immS, ADD, mem_we=1, mem_wdata=rs2; funct3 ≤ 010.
  - MISC-MEM (FENCE): issue as NOP (ADD, A=B=0, no side effects).
  - All other opcodes, including SYSTEM: illegal.
- Illegal bundle: out_valid=1, illegal=1, ADD, A=B=0, and wb_en, mem_re, mem_we, is_branch, is_jump all 0.
- wb_en=1 only for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD, and only when rd≠0.
- Width rules: pc+imm and pc+4 wrap modulo 2^32; no alignment checks in this block.

Decomposition:
- Shared package rv32_pkg holds:
  - alu_func_e (4-bit enum with the values above; shared with the ALU);
  - opcode constants;
  - funct3/funct7 constants;
  - issue_bundle_t struct.
- One combinational sub-module, rv32_decode (instr, pc, rs1/rs2 data → issue_bundle_t).
- alu_issue wraps rv32_decode with the handshake register.

Test Plan:
- ADDI x1,x2,-5 (0xFFB10093), rs1_data=10 → next cycle out_valid=1, func=0, A=10, B=0xFFFFFFFB, rd=1, wb_en=1.
- SUB x3,x1,x2 (0x402081B3) → func=1, A=rs1_data, B=rs2_data, rd=3. SRAI x5,x6,3 (0x40335293) → func=7, B=3.
- BEQ with pc=0x100, immB=+16 → is_branch=1, br_funct3=0, func=1, tgt=0x110, wb_en=0. JALR x1,0(x2) → func=10, link_val=pc+4, is_jump=1.
- Backpressure: out_ready=0 while two instructions are offered → first bundle is held unchanged and in_ready=0. Raise out_ready → second bundle is issued the cycle after.
- flush=1 with out_valid=1 and in_valid=1 → out_valid=0 next cycle and the incoming instruction is never issued. Separately, 0x00000000 → illegal=1 with all side-effect bits 0.
- rst_n pulled low asynchronously mid-stall → out_valid=0 immediately. After release, in_ready=1 and the first new instruction issues normally.
